// File: rtl/rr_arb_pkg.sv
// Shared constants and types for the four-way round-robin arbiter.
package rr_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } search_t;

endpackage

// File: rtl/arb_onehot_dec.sv
// Combinational index-to-one-hot decoder; output is all zeros when disabled.
module arb_onehot_dec
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    input  logic               en,
    output logic [NUM_REQ-1:0] onehot
);

    // One-hot decode gated by the enable
    always_comb begin
        onehot = {NUM_REQ{1'b0}};
        if (en) begin
            onehot = NUM_REQ'(1) << idx;
        end else begin
            onehot = {NUM_REQ{1'b0}};
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with hold-limit preemption of a long-running owner.
module rr_arbiter4
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               preempt
);

    localparam logic             PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST  = (MAX_HOLD == 0) ? {CNT_W{1'b0}} : CNT_W'(MAX_HOLD - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic               preempt_q, preempt_d;

    logic [NUM_REQ-1:0] others_s;
    search_t            idle_win_s;
    search_t            next_win_s;

    function automatic search_t rr_search(input logic [NUM_REQ-1:0] mask,
                                          input logic [IDX_W-1:0]   start);
        search_t          res;
        logic [IDX_W-1:0] cand;
        res = '{found: 1'b0, idx: {IDX_W{1'b0}}};
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = start + IDX_W'(i);
            if (!res.found && mask[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next owner, pointer, hold counter and preempt pulse
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        preempt_d  = 1'b0;
        // The old owner is masked out so a timeout can never re-grant it.
        others_s   = req & ~(NUM_REQ'(1) << idx_q);
        idle_win_s = rr_search(req, ptr_q);
        next_win_s = rr_search(others_s, idx_q + IDX_W'(1));
        case (state_q)
            IDLE: begin
                if (idle_win_s.found) begin
                    state_d = GRANT;
                    idx_d   = idle_win_s.idx;
                    hold_d  = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!req[idx_q]) begin
                    ptr_d  = idx_q + IDX_W'(1);
                    hold_d = {CNT_W{1'b0}};
                    if (next_win_s.found) begin
                        idx_d = next_win_s.idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (PREEMPT_EN && (hold_q == HOLD_LAST) && next_win_s.found) begin
                    idx_d     = next_win_s.idx;
                    ptr_d     = idx_q + IDX_W'(1);
                    hold_d    = {CNT_W{1'b0}};
                    preempt_d = 1'b1;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + CNT_W'(1);
                end else begin
                    hold_d = hold_q;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = {CNT_W{1'b0}};
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= {IDX_W{1'b0}};
            ptr_q     <= {IDX_W{1'b0}};
            hold_q    <= {CNT_W{1'b0}};
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt_valid = (state_q == GRANT);
    assign gnt_idx   = idx_q;
    assign preempt   = preempt_q;

    arb_onehot_dec u_dec (
        .idx    (idx_q),
        .en     (gnt_valid),
        .onehot (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: an owner/queue-level model checked every cycle plus directed literal checks.
module tb_rr_arbiter4;

    localparam int M = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b1111;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int n_chk = 0;
    int n_err = 0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_pre   = 1'b0;
    bit m_live  = 1'b0;

    rr_arbiter4 #(.MAX_HOLD(M), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First requester (scanning upward from start, mod 4, skipping skip) that is asking
    function automatic int pick(input logic [3:0] r, input int start, input int skip);
        for (int i = 0; i < 4; i++) begin
            int c;
            c = (start + i) % 4;
            if (c != skip && r[c]) return c;
        end
        return -1;
    endfunction

    // Reference model: tracks who owns the resource and for how many cycles
    always @(posedge clk) begin
        if (!rst_n) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_pre = 1'b0; m_live = 1'b1;
        end else begin
            m_pre = 1'b0;
            if (m_owner < 0) begin
                m_owner = pick(req, m_ptr, -1);
                m_held  = 1;
            end else if (!req[m_owner]) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = pick(req, m_ptr, -1);
                m_held  = 1;
            end else if (m_held >= M && pick(req, m_owner + 1, m_owner) >= 0) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = pick(req, m_ptr, m_owner);
                m_held  = 1;
                m_pre   = 1'b1;
            end else if (m_held < 1000) begin
                m_held++;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_live) begin
            logic [3:0] eg;
            eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            check("model_gnt", {4'b0000, gnt}, {4'b0000, eg});
            check("model_valid", {7'b0, gnt_valid}, {7'b0, m_owner >= 0});
            check("model_preempt", {7'b0, preempt}, {7'b0, m_pre});
            if (m_owner >= 0) check("model_idx", {6'b0, gnt_idx}, 8'(m_owner));
        end
    end

    task automatic apply(input logic [3:0] r, input logic rn);
        req = r;
        rst_n = rn;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string name, input logic [3:0] eg, input logic ep);
        check({name, "_gnt"}, {4'b0000, gnt}, {4'b0000, eg});
        check({name, "_preempt"}, {7'b0, preempt}, {7'b0, ep});
    endtask

    initial begin
        // Reset with all requests high
        apply(4'b1111, 1'b0);
        apply(4'b1111, 1'b0);
        expect_out("reset", 4'b0000, 1'b0);
        check("reset_idx", {6'b0, gnt_idx}, 8'd0);
        check("reset_valid", {7'b0, gnt_valid}, 8'd0);
        apply(4'b1111, 1'b1);
        expect_out("first", 4'b0001, 1'b0);
        check("first_idx", {6'b0, gnt_idx}, 8'd0);

        // Rotation under full contention, four cycles per owner
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < M; c++) begin
                logic [3:0] eg;
                if (!(k == 0 && c == 0)) apply(4'b1111, 1'b1);
                eg = 4'b0001 << (k % 4);
                expect_out("rotate", eg, (c == 0 && k != 0));
            end
        end

        // Release handoff from owner 2 to 3
        apply(4'b0000, 1'b0);
        apply(4'b0100, 1'b1);
        expect_out("own2", 4'b0100, 1'b0);
        apply(4'b1011, 1'b1);
        expect_out("handoff3", 4'b1000, 1'b0);

        // Release handoff from owner 2 wrapping to 0
        apply(4'b0000, 1'b0);
        apply(4'b0100, 1'b1);
        apply(4'b0011, 1'b1);
        expect_out("handoff_wrap", 4'b0001, 1'b0);

        // Lone owner never preempted, then release to idle
        apply(4'b0000, 1'b0);
        for (int i = 0; i < 20; i++) begin
            apply(4'b0100, 1'b1);
            expect_out("lone", 4'b0100, 1'b0);
        end
        apply(4'b0000, 1'b1);
        expect_out("lone_release", 4'b0000, 1'b0);
        check("lone_release_valid", {7'b0, gnt_valid}, 8'd0);

        // Release in the same cycle the hold limit is reached
        apply(4'b0000, 1'b0);
        for (int i = 0; i < M; i++) begin
            apply(4'b0101, 1'b1);
            expect_out("simul_hold", 4'b0001, 1'b0);
        end
        apply(4'b0100, 1'b1);
        expect_out("simul_release", 4'b0100, 1'b0);

        // Reset mid-grant clears the round-robin pointer
        apply(4'b0000, 1'b0);
        apply(4'b0010, 1'b1);
        apply(4'b0100, 1'b1);
        apply(4'b0010, 1'b1);
        expect_out("pre_reset", 4'b0010, 1'b0);
        apply(4'b0010, 1'b0);
        expect_out("mid_reset", 4'b0000, 1'b0);
        apply(4'b1010, 1'b1);
        expect_out("ptr_cleared", 4'b0010, 1'b0);
        apply(4'b0010, 1'b0);
        apply(4'b0110, 1'b1);
        expect_out("after_reset", 4'b0010, 1'b0);

        // Short mixed sequence left to the every-cycle model
        apply(4'b1110, 1'b1);
        apply(4'b1100, 1'b1);
        apply(4'b1001, 1'b1);
        apply(4'b1001, 1'b1);
        apply(4'b0001, 1'b1);
        apply(4'b0000, 1'b1);
        apply(4'b1000, 1'b1);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-way round-robin arbiter that shares one resource (bus, register-file write port, memory bank) among four requesters. It registers a 2-bit owner index and drives a one-hot grant vector decoded from that index. A hold-limit counter preempts an owner that keeps the resource past `MAX_HOLD` cycles while others wait. It sits between requester blocks and the shared resource's enable/select inputs.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while other requests are pending; 0 disables preemption.
- `CNT_W`, default 4: hold-counter width; must satisfy 2^CNT_W ≥ MAX_HOLD.

- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req`  in  4  request per requester; held high for the whole time the resource is wanted
- `gnt`  out  4  one-hot grant; 4'b0000 when no owner
- `gnt_idx`  out  2  owner index; valid only when `gnt_valid`=1
- `gnt_valid`  out  1  a grant is active
- `preempt`  out  1  one-cycle pulse, same cycle as the new grant that replaced a timed-out owner

## Operation
- States: IDLE (no owner) and GRANT (owner = `gnt_idx`).
- Internal round-robin pointer `ptr` (2 bits): the first requester searched.
- Winner search: scan `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4). The first index with `req` high wins.
- IDLE, any `req` high: register the winner and go to GRANT. Set `hold_cnt`=0.
- GRANT, `req[gnt_idx]`=0 (release):
  - If other requests are pending, search from `gnt_idx`+1 and register the new owner directly, with no idle bubble.
  - Otherwise go to IDLE.
  - In both cases, `ptr` ← old `gnt_idx`+1.
- GRANT, owner still requesting, `MAX_HOLD`≠0, `hold_cnt`==`MAX_HOLD`−1, and any other `req` high (timeout):
  - Grant passes to the winner of a search from `gnt_idx`+1 that excludes the old owner.
  - `preempt`=1 for that cycle. `ptr` ← old `gnt_idx`+1. `hold_cnt`=0.
- GRANT, owner still requesting, no timeout: `hold_cnt` increments and saturates at `MAX_HOLD`−1. With no competitors, the owner keeps the grant indefinitely.
- Release takes precedence over timeout in the same cycle, so `preempt` stays 0.
- `gnt` = decode(`gnt_idx`) gated by `gnt_valid`. It is always one-hot or zero and never multi-hot.
- Requests from non-owners never disturb the current owner except through timeout.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE; `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `preempt`=0; `ptr`=0, `hold_cnt`=0. Reset overrides all other events, including during GRANT.
- Request to grant: 1 cycle. A `req` sampled high at edge N gives `gnt` high after edge N.
- Release to next grant: 1 cycle. The owner's `req` low at edge N moves `gnt` to the next owner (or 0) after edge N.
- With `MAX_HOLD`=M and competition, the owner sees `gnt` for exactly M cycles.
- All outputs are registered. There is no combinational path from `req` to `gnt`.
- Index wrap: 3+1 → 0.

## Structure
- Shared package/header `rr_arb_pkg` holds:
  - `NUM_REQ`=4 and `IDX_W`=2
  - state encoding: IDLE=1'b0, GRANT=1'b1
- Sub-module `arb_onehot_dec`: 2-bit index plus enable in, 4-bit one-hot out, purely combinational. It is the only source of `gnt`.
- The round-robin search is a function or always block inside `rr_arbiter4`.

## Test plan
- Reset: `rst_n`=0 for 2 cycles with `req`=4'b1111 → all outputs 0. After release, the first edge gives `gnt`=4'b0001, `gnt_idx`=0.
- Rotation: `MAX_HOLD`=4, `req`=4'b1111 held → grants 0,1,2,3,0 in turn, each exactly 4 cycles. `preempt` pulses at each change. `gnt` is never 0 between owners.
- Release handoff: owner 2 drops `req`, giving `req`=4'b1011 → next cycle `gnt`=4'b1000, `preempt`=0. With `req`=4'b0011 instead, `gnt`=4'b0001 (wrap).
- Lone owner: `req`=4'b0100 for 20 cycles with `MAX_HOLD`=4 → `gnt`=4'b0100 continuously and `preempt` never asserts. `req`→0 gives `gnt`=0 next cycle.
- Simultaneous release and timeout: at `hold_cnt`=3 the owner drops `req` while others are pending → handoff occurs with `preempt`=0.
- Reset mid-grant: `rst_n`=0 for one cycle while `gnt`=4'b0010 → `gnt`=0 after that edge. Then `req`=4'b0110 gives `gnt`=4'b0010, because `ptr` was reset to 0.
